// File: rtl/ddr_pkg.sv
// Shared defaults and types for the DDR controller user-side datapath.
// The top module and the bench both import this package.
package ddr_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_OWNER_WIDTH  = 2;
   localparam int DEF_READ_LATENCY = 3;

   typedef logic [DEF_OWNER_WIDTH-1:0] owner_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid+tag shift register that tracks in-flight reads.
// hold_i freezes every stage, so the remaining latency of each entry is preserved.
module rd_tag_pipe #(
   parameter int DEPTH     = 3,
   parameter int TAG_WIDTH = 2
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 hold_i,
   input  logic                 push_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   output logic                 valid_o,
   output logic [TAG_WIDTH-1:0] tag_o
);

   logic [DEPTH-1:0]                valid_q, valid_d;
   logic [DEPTH-1:0][TAG_WIDTH-1:0] tag_q, tag_d;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      if (!hold_i) begin
         valid_d[0] = push_i;
         tag_d[0]   = tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/datapath.sv
// User-side data/owner datapath between the command FSM and the DDR PHY:
// owner tagging of reads, fixed-latency read return, and registered write data.
module datapath
   import ddr_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int OWNER_WIDTH  = DEF_OWNER_WIDTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic [DATA_WIDTH-1:0]  usr_data_i,
   input  logic [OWNER_WIDTH-1:0] usr_owner_i,
   output logic [DATA_WIDTH-1:0]  usr_data_o,
   output logic [OWNER_WIDTH-1:0] usr_owner_o,
   output logic                   usr_ready_o,
   input  logic                   ctl_start_i,
   input  logic                   ctl_block_i,
   input  logic                   ctl_suspend_i,
   input  logic                   ctl_read_i,
   input  logic                   ctl_write_i,
   output logic                   ddr_send_o,
   output logic [DATA_WIDTH-1:0]  ddr_data_o,
   input  logic [DATA_WIDTH-1:0]  ddr_data_i
);

   logic                   cmd_ok;
   logic                   start_acc, read_acc, write_acc;
   logic                   pipe_valid;
   logic [OWNER_WIDTH-1:0] pipe_tag, push_tag;

   logic [OWNER_WIDTH-1:0] owner_q, owner_d;
   logic [DATA_WIDTH-1:0]  usr_data_q, usr_data_d;
   logic [OWNER_WIDTH-1:0] usr_owner_q, usr_owner_d;
   logic                   usr_ready_q, usr_ready_d;
   logic                   ddr_send_q, ddr_send_d;
   logic [DATA_WIDTH-1:0]  ddr_data_q, ddr_data_d;

   assign cmd_ok    = !ctl_block_i && !ctl_suspend_i;
   assign start_acc = ctl_start_i && cmd_ok;
   assign read_acc  = ctl_read_i && cmd_ok;
   assign write_acc = ctl_write_i && cmd_ok;
   // A start on the same edge as the read supplies the tag directly.
   assign push_tag  = start_acc ? usr_owner_i : owner_q;

   rd_tag_pipe #(
      .DEPTH     (READ_LATENCY),
      .TAG_WIDTH (OWNER_WIDTH)
   ) u_rd_tag_pipe (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .hold_i  (ctl_suspend_i),
      .push_i  (read_acc && !write_acc),
      .tag_i   (push_tag),
      .valid_o (pipe_valid),
      .tag_o   (pipe_tag)
   );

   always_comb begin
      owner_d     = start_acc ? usr_owner_i : owner_q;
      usr_ready_d = pipe_valid && !ctl_suspend_i;
      usr_data_d  = usr_ready_d ? ddr_data_i : usr_data_q;
      usr_owner_d = usr_ready_d ? pipe_tag : usr_owner_q;
      ddr_send_d  = write_acc;
      ddr_data_d  = write_acc ? usr_data_i : ddr_data_q;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         owner_q     <= '0;
         usr_data_q  <= '0;
         usr_owner_q <= '0;
         usr_ready_q <= 1'b0;
         ddr_send_q  <= 1'b0;
         ddr_data_q  <= '0;
      end else begin
         owner_q     <= owner_d;
         usr_data_q  <= usr_data_d;
         usr_owner_q <= usr_owner_d;
         usr_ready_q <= usr_ready_d;
         ddr_send_q  <= ddr_send_d;
         ddr_data_q  <= ddr_data_d;
      end
   end

   assign usr_data_o  = usr_data_q;
   assign usr_owner_o = usr_owner_q;
   assign usr_ready_o = usr_ready_q;
   assign ddr_send_o  = ddr_send_q;
   assign ddr_data_o  = ddr_data_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: reads queue their expected return edge and owner,
// the negedge monitor pops and compares whenever usr_ready_o pulses.
module tb_datapath;
   import ddr_pkg::*;

   localparam int          DW  = 32;
   localparam int          OW  = 2;
   localparam int          L   = 3;
   localparam logic [31:0] PAT = 32'hA5A5_0000;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b0;
   logic [DW-1:0] usr_data_i = '0;
   owner_t        usr_owner_i = '0;
   logic [DW-1:0] usr_data_o;
   owner_t        usr_owner_o;
   logic          usr_ready_o;
   logic          ctl_start_i = 1'b0;
   logic          ctl_block_i = 1'b0;
   logic          ctl_suspend_i = 1'b0;
   logic          ctl_read_i = 1'b0;
   logic          ctl_write_i = 1'b0;
   logic          ddr_send_o;
   logic [DW-1:0] ddr_data_o;
   logic [DW-1:0] ddr_data_i = '0;

   always #5 clock_i = ~clock_i;

   datapath #(
      .DATA_WIDTH   (DW),
      .OWNER_WIDTH  (OW),
      .READ_LATENCY (L)
   ) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .usr_data_i    (usr_data_i),
      .usr_owner_i   (usr_owner_i),
      .usr_data_o    (usr_data_o),
      .usr_owner_o   (usr_owner_o),
      .usr_ready_o   (usr_ready_o),
      .ctl_start_i   (ctl_start_i),
      .ctl_block_i   (ctl_block_i),
      .ctl_suspend_i (ctl_suspend_i),
      .ctl_read_i    (ctl_read_i),
      .ctl_write_i   (ctl_write_i),
      .ddr_send_o    (ddr_send_o),
      .ddr_data_o    (ddr_data_o),
      .ddr_data_i    (ddr_data_i)
   );

   typedef struct {
      int     ret_edge;
      owner_t owner;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            edge_cnt = 0;
   logic [DW-1:0] last_wr = '0;
   owner_t        owner_m = '0;

   always @(posedge clock_i) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ddr_data_i carries the number of the edge that will sample it.
   always @(negedge clock_i) begin
      exp_t e;
      if (!reset_i && usr_ready_o) begin
         if (sb.size() == 0) begin
            chk("spurious_ready", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            $display("rd return edge=%0d owner=%0d data=%h", edge_cnt, usr_owner_o, usr_data_o);
            chk("ready_edge", 64'(edge_cnt), 64'(e.ret_edge));
            chk("rd_owner", 64'(usr_owner_o), 64'(e.owner));
            chk("rd_data", 64'(usr_data_o), 64'(PAT ^ 32'(e.ret_edge)));
         end
      end
      ddr_data_i = PAT ^ 32'(edge_cnt + 1);
   end

   task automatic step(input logic st, input owner_t own, input logic rd, input logic wr,
                       input logic [DW-1:0] dat, input logic blk, input logic sus);
      int  n;
      logic acc;
      ctl_start_i   = st;
      usr_owner_i   = own;
      ctl_read_i    = rd;
      ctl_write_i   = wr;
      usr_data_i    = dat;
      ctl_block_i   = blk;
      ctl_suspend_i = sus;
      @(posedge clock_i);
      #1;
      n   = edge_cnt;
      acc = !blk && !sus;
      if (sus) begin
         foreach (sb[i]) if (sb[i].ret_edge >= n) sb[i].ret_edge++;
      end
      if (acc && rd && !wr) sb.push_back('{n + L, (st ? own : owner_m)});
      if (acc && st) owner_m = own;
      if (acc && wr) last_wr = dat;
      chk("send", 64'(ddr_send_o), 64'(acc && wr));
      chk("wr_data", 64'(ddr_data_o), 64'(last_wr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_usr_data"}, 64'(usr_data_o), 64'd0);
      chk({tag, "_usr_owner"}, 64'(usr_owner_o), 64'd0);
      chk({tag, "_usr_ready"}, 64'(usr_ready_o), 64'd0);
      chk({tag, "_ddr_send"}, 64'(ddr_send_o), 64'd0);
      chk({tag, "_ddr_data"}, 64'(ddr_data_o), 64'd0);
   endtask

   initial begin
      #1 reset_i = 1'b1;
      #1 check_outputs_zero("reset");
      @(negedge clock_i);
      @(negedge clock_i);
      reset_i = 1'b0;

      // start owner 1, then a plain read tagged from owner_q
      step(1'b1, 2'd1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 2'd2, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      idle(4);

      // write: one send strobe, data held afterwards
      step(1'b0, 2'd0, 1'b0, 1'b1, 32'd1298, 1'b0, 1'b0);
      idle(2);

      // back-to-back reads, each with a restart in the same edge
      step(1'b1, 2'd2, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 2'd3, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      idle(4);

      // two suspended cycles mid-pipeline; the write under suspend is ignored
      step(1'b0, 2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1);
      step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      idle(6);

      // blocked start/read/write do nothing; owner stays 3
      step(1'b1, 2'd0, 1'b1, 1'b1, 32'h77, 1'b1, 1'b0);
      step(1'b0, 2'd1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      idle(4);

      // read and write on the same edge: only the write happens
      step(1'b0, 2'd0, 1'b1, 1'b1, 32'hCAFE, 1'b0, 1'b0);
      idle(4);

      // block does not stall a read already in flight
      step(1'b0, 2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // randomised mix of all controls
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 3) == 0), owner_t'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
              32'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      end
      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
      chk("drain", 64'(sb.size()), 64'd0);

      // reset while a read is in flight: dropped, no ready afterwards
      step(1'b1, 2'd2, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b0);
      #2 reset_i = 1'b1;
      #1 check_outputs_zero("midreset");
      sb.delete();
      last_wr = '0;
      owner_m = '0;
      @(posedge clock_i);
      @(negedge clock_i);
      reset_i = 1'b0;
      idle(6);
      step(1'b0, 2'd3, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
      chk("final_drain", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
